// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: collects floor requests into a pending bitmap and
// steers the car with collective (sweep) service plus a timed door dwell.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - synchronous reset, active-high (1 resets on next edge)
//   req_valid      - floor-request strobe, one request per cycle
//   req_floor      - requested floor index
//   current_floor  - car position from the car controller
//   car_moving     - 1 while the car travels between floors
//   target_floor   - registered floor the car shall travel to
//   dir_up         - registered service direction, 1 = up
//   door_open      - registered, 1 while dwelling
//   pending        - registered outstanding-request bitmap
//   req_reject     - registered one-cycle pulse for an ignored request
module elevator_request_scheduler #(
  parameter int unsigned NUM_FLOORS   = 10,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
  input  logic [3:0]            current_floor,
  input  logic                  car_moving,
  output logic [3:0]            target_floor,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_reject
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_SERVE_UP   = 2'd1;
  localparam logic [1:0] S_SERVE_DOWN = 2'd2;
  localparam logic [1:0] S_DWELL      = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [3:0]            target_q, target_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_q, door_d;
  logic                  reject_q, reject_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  req_oob, req_served, accept;
  logic [NUM_FLOORS-1:0] set_mask, cur_mask, view;
  logic                  any_above, any_below, at_floor, clear_here;
  logic [3:0]            low_above, high_below;

  // Request qualification and floor scans. Direction decisions look at the
  // pending bitmap merged with this cycle's accepted request, so a new floor
  // ahead of the car retargets it on the very next edge. The "stop here"
  // decision uses only registered pending bits.
  always_comb begin
    req_oob    = 32'(req_floor) >= NUM_FLOORS;
    req_served = (state_q == S_DWELL) && (req_floor == current_floor);
    accept     = req_valid && !req_oob && !req_served;
    reject_d   = req_valid && (req_oob || req_served);
    set_mask   = '0;
    cur_mask   = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      set_mask[i] = accept && (4'(i) == req_floor);
      cur_mask[i] = (4'(i) == current_floor);
    end
    view      = pending_q | set_mask;
    at_floor  = |(pending_q & cur_mask);
    any_above = 1'b0;
    any_below = 1'b0;
    low_above  = 4'd0;
    high_below = 4'd0;
    // Descending scan: last hit above the car is the lowest one.
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (view[i] && (4'(i) > current_floor)) begin
        any_above = 1'b1;
        low_above = 4'(i);
      end
    end
    // Ascending scan: last hit below the car is the highest one.
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (view[i] && (4'(i) < current_floor)) begin
        any_below  = 1'b1;
        high_below = 4'(i);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    clear_here = 1'b0;

    case (state_q)
      S_IDLE: begin
        target_d = current_floor;
        if (at_floor && !car_moving) begin
          state_d    = S_DWELL;
          clear_here = 1'b1;
          cnt_d      = '0;
        end else if (any_above) begin
          state_d  = S_SERVE_UP;
          target_d = low_above;
          dir_up_d = 1'b1;
        end else if (any_below) begin
          state_d  = S_SERVE_DOWN;
          target_d = high_below;
          dir_up_d = 1'b0;
        end
      end

      S_SERVE_UP: begin
        // While at the target but still settling, hold the target.
        if (current_floor == target_q) begin
          if (!car_moving) begin
            state_d    = S_DWELL;
            clear_here = 1'b1;
            cnt_d      = '0;
          end
        end else if (any_above) begin
          target_d = low_above;
        end else if (any_below) begin
          state_d  = S_SERVE_DOWN;
          target_d = high_below;
          dir_up_d = 1'b0;
        end else begin
          state_d  = S_IDLE;
          target_d = current_floor;
        end
      end

      S_SERVE_DOWN: begin
        if (current_floor == target_q) begin
          if (!car_moving) begin
            state_d    = S_DWELL;
            clear_here = 1'b1;
            cnt_d      = '0;
          end
        end else if (any_below) begin
          target_d = high_below;
        end else if (any_above) begin
          state_d  = S_SERVE_UP;
          target_d = low_above;
          dir_up_d = 1'b1;
        end else begin
          state_d  = S_IDLE;
          target_d = current_floor;
        end
      end

      S_DWELL: begin
        target_d = current_floor;
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          // Keep sweeping the same way if possible, otherwise reverse.
          if (dir_up_q ? any_above : !any_below && any_above) begin
            state_d  = S_SERVE_UP;
            target_d = low_above;
            dir_up_d = 1'b1;
          end else if (any_below) begin
            state_d  = S_SERVE_DOWN;
            target_d = high_below;
            dir_up_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    door_d    = (state_d == S_DWELL);
    // Clear beats set when both hit the same bit.
    pending_d = (pending_q | set_mask) & ~(clear_here ? cur_mask : '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      target_q  <= 4'd0;
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      reject_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      door_q    <= door_d;
      reject_q  <= reject_d;
      cnt_q     <= cnt_d;
    end
  end

  assign target_floor = target_q;
  assign dir_up       = dir_up_q;
  assign door_open    = door_q;
  assign pending      = pending_q;
  assign req_reject   = reject_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed self-checking bench for elevator_request_scheduler (defaults:
// 10 floors, 4-cycle dwell). Inputs change 1 ns after each rising edge and
// outputs are sampled at that same point.
module tb_elevator_request_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_floor;
  logic [3:0] current_floor;
  logic       car_moving;
  logic [3:0] target_floor;
  logic       dir_up;
  logic       door_open;
  logic [9:0] pending;
  logic       req_reject;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_request_scheduler #(.NUM_FLOORS(10), .DWELL_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .current_floor(current_floor),
    .car_moving   (car_moving),
    .target_floor (target_floor),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .pending      (pending),
    .req_reject   (req_reject)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] floor);
    rst_n = 1'b1; req_valid = 1'b0; req_floor = 4'd0;
    car_moving = 1'b0; current_floor = floor;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b1; req_floor = 4'd3;
    current_floor = 4'd6; car_moving = 1'b0;
    tick(); tick();
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL rst_pending got %h exp %h", pending, 10'h000); end
    n_checks++; if (target_floor !== 4'd0) begin n_fail++; $display("FAIL rst_target got %0d exp 0", target_floor); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL rst_dir got %b exp 1", dir_up); end
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL rst_door got %b exp 0", door_open); end
    n_checks++; if (req_reject !== 1'b0) begin n_fail++; $display("FAIL rst_reject got %b exp 0", req_reject); end
    rst_n = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_first_request();
    do_reset(4'd0);
    req_valid = 1'b1; req_floor = 4'd5;
    tick();
    n_checks++; if (pending !== 10'h020) begin n_fail++; $display("FAIL first_pending got %h exp %h", pending, 10'h020); end
    n_checks++; if (target_floor !== 4'd5) begin n_fail++; $display("FAIL first_target got %0d exp 5", target_floor); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL first_dir got %b exp 1", dir_up); end
    // Arrive at 5 while re-requesting 5: arrival clear beats the set.
    current_floor = 4'd5;
    tick();
    req_valid = 1'b0;
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL clear_wins got %h exp %h", pending, 10'h000); end
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL arrive_door got %b exp 1", door_open); end
    n_checks++; if (req_reject !== 1'b0) begin n_fail++; $display("FAIL arrive_reject got %b exp 0", req_reject); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (door_open !== (k < 3)) begin n_fail++; $display("FAIL dwell_len k=%0d got %b exp %b", k, door_open, (k < 3)); end
    end
  endtask

  task automatic test_collective();
    do_reset(4'd2);
    req_valid = 1'b1; req_floor = 4'd7;
    tick();
    n_checks++; if (target_floor !== 4'd7) begin n_fail++; $display("FAIL coll_t7 got %0d exp 7", target_floor); end
    car_moving = 1'b1; req_floor = 4'd4;
    tick();
    req_valid = 1'b0;
    n_checks++; if (target_floor !== 4'd4) begin n_fail++; $display("FAIL coll_t4 got %0d exp 4", target_floor); end
    n_checks++; if (pending !== 10'h090) begin n_fail++; $display("FAIL coll_pend got %h exp %h", pending, 10'h090); end
    current_floor = 4'd4;
    tick();
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL coll_moving_door got %b exp 0", door_open); end
    car_moving = 1'b0;
    tick();
    n_checks++; if (pending !== 10'h080) begin n_fail++; $display("FAIL coll_clear4 got %h exp %h", pending, 10'h080); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL coll_dwell k=%0d got %b exp 1", k, door_open); end
    end
    tick();
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL coll_exit_door got %b exp 0", door_open); end
    n_checks++; if (target_floor !== 4'd7) begin n_fail++; $display("FAIL coll_resume got %0d exp 7", target_floor); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL coll_dir got %b exp 1", dir_up); end
  endtask

  task automatic test_both_directions();
    do_reset(4'd3);
    req_valid = 1'b1; req_floor = 4'd3;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL both_dwell got %b exp 1", door_open); end
    req_valid = 1'b1; req_floor = 4'd1;
    tick();
    req_floor = 4'd6;
    tick();
    req_valid = 1'b0;
    n_checks++; if (pending !== 10'h042) begin n_fail++; $display("FAIL both_pend got %h exp %h", pending, 10'h042); end
    tick(); tick();
    n_checks++; if (target_floor !== 4'd6) begin n_fail++; $display("FAIL both_up_target got %0d exp 6", target_floor); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL both_up_dir got %b exp 1", dir_up); end
    current_floor = 4'd6;
    tick();
    n_checks++; if (pending !== 10'h002) begin n_fail++; $display("FAIL both_clear6 got %h exp %h", pending, 10'h002); end
    tick(); tick(); tick(); tick();
    n_checks++; if (target_floor !== 4'd1) begin n_fail++; $display("FAIL both_down_target got %0d exp 1", target_floor); end
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL both_down_dir got %b exp 0", dir_up); end
    current_floor = 4'd1;
    tick();
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL both_clear1 got %h exp %h", pending, 10'h000); end
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL both_dwell_dir got %b exp 0", dir_up); end
  endtask

  task automatic test_reject();
    do_reset(4'd0);
    req_valid = 1'b1; req_floor = 4'd12;
    tick();
    n_checks++; if (req_reject !== 1'b1) begin n_fail++; $display("FAIL rej12 got %b exp 1", req_reject); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL rej12_pend got %h exp %h", pending, 10'h000); end
    req_floor = 4'd10;
    tick();
    n_checks++; if (req_reject !== 1'b1) begin n_fail++; $display("FAIL rej10 got %b exp 1", req_reject); end
    req_floor = 4'd9;
    tick();
    n_checks++; if (req_reject !== 1'b0) begin n_fail++; $display("FAIL acc9_reject got %b exp 0", req_reject); end
    n_checks++; if (pending !== 10'h200) begin n_fail++; $display("FAIL acc9_pend got %h exp %h", pending, 10'h200); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (req_reject !== 1'b0) begin n_fail++; $display("FAIL rereq_reject got %b exp 0", req_reject); end
    n_checks++; if (pending !== 10'h200) begin n_fail++; $display("FAIL rereq_pend got %h exp %h", pending, 10'h200); end
    n_checks++; if (target_floor !== 4'd9) begin n_fail++; $display("FAIL rereq_target got %0d exp 9", target_floor); end
  endtask

  task automatic test_dwell_at_idle_floor();
    do_reset(4'd4);
    req_valid = 1'b1; req_floor = 4'd4;
    tick();
    req_valid = 1'b0;
    n_checks++; if (pending !== 10'h010) begin n_fail++; $display("FAIL idle4_pend got %h exp %h", pending, 10'h010); end
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL idle4_door0 got %b exp 0", door_open); end
    tick();
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL idle4_door1 got %b exp 1", door_open); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL idle4_clear got %h exp %h", pending, 10'h000); end
    req_valid = 1'b1; req_floor = 4'd4;
    tick();
    req_valid = 1'b0;
    n_checks++; if (req_reject !== 1'b1) begin n_fail++; $display("FAIL served_reject got %b exp 1", req_reject); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL served_pend got %h exp %h", pending, 10'h000); end
    tick();
    n_checks++; if (req_reject !== 1'b0) begin n_fail++; $display("FAIL reject_pulse got %b exp 0", req_reject); end
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL idle4_door3 got %b exp 1", door_open); end
    tick();
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL idle4_door4 got %b exp 1", door_open); end
    tick();
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL idle4_exit got %b exp 0", door_open); end
    n_checks++; if (target_floor !== 4'd4) begin n_fail++; $display("FAIL idle4_target got %0d exp 4", target_floor); end
  endtask

  task automatic test_reset_in_dwell();
    do_reset(4'd5);
    req_valid = 1'b1; req_floor = 4'd5;
    tick();
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_floor = 4'd6;
    tick();
    req_floor = 4'd7;
    tick();
    n_checks++; if (pending !== 10'h0C0) begin n_fail++; $display("FAIL rd_pend got %h exp %h", pending, 10'h0C0); end
    n_checks++; if (door_open !== 1'b1) begin n_fail++; $display("FAIL rd_door got %b exp 1", door_open); end
    rst_n = 1'b1; req_floor = 4'd2;
    tick();
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL rd_rst_pend got %h exp %h", pending, 10'h000); end
    n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL rd_rst_door got %b exp 0", door_open); end
    n_checks++; if (target_floor !== 4'd0) begin n_fail++; $display("FAIL rd_rst_target got %0d exp 0", target_floor); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL rd_rst_dir got %b exp 1", dir_up); end
    rst_n = 1'b0;
    tick();
    req_valid = 1'b0;
    n_checks++; if (pending !== 10'h004) begin n_fail++; $display("FAIL post_rst_pend got %h exp %h", pending, 10'h004); end
    n_checks++; if (target_floor !== 4'd2) begin n_fail++; $display("FAIL post_rst_target got %0d exp 2", target_floor); end
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL post_rst_dir got %b exp 0", dir_up); end
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_floor = 4'd0;
    current_floor = 4'd0; car_moving = 1'b0;
    test_reset();
    test_first_request();
    test_collective();
    test_both_directions();
    test_reject();
    test_dwell_at_idle_floor();
    test_reset_in_dwell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (2..16).
REQ-002 SHALL have parameter DWELL_CYCLES, default 4, door-open duration in clocks (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-high (rst_n=1 resets on the next clk rising edge).
REQ-005 SHALL have port req_valid  input  1  floor-request strobe, one request per cycle.
REQ-006 SHALL have port req_floor  input  4  requested floor index, sampled when req_valid=1.
REQ-007 SHALL have port current_floor  input  4  car position reported by the car controller.
REQ-008 SHALL have port car_moving  input  1  1 while the car is travelling between floors.
REQ-009 SHALL have port target_floor  output  4  registered floor the car shall travel to.
REQ-010 SHALL have port dir_up  output  1  registered; 1 = current service direction up.
REQ-011 SHALL have port door_open  output  1  registered; 1 during DWELL.
REQ-012 SHALL have port pending  output  NUM_FLOORS  registered outstanding-request bitmap, bit i = floor i.
REQ-013 SHALL have port req_reject  output  1  registered one-cycle pulse for an ignored request.

Function
REQ-014 SHALL implement states IDLE, SERVE_UP, SERVE_DOWN, DWELL in a registered FSM.
REQ-015 Accepted request (req_valid=1, req_floor<NUM_FLOORS) SHALL set pending[req_floor] on the next edge; re-request of a set bit: no change, no reject.
REQ-016 Request with req_floor>=NUM_FLOORS SHALL leave pending unchanged and pulse req_reject next cycle.
REQ-017 Request for current_floor while in DWELL SHALL not set pending and SHALL pulse req_reject (already served).
REQ-018 "above"/"below" SHALL mean any pending bit with index >/< current_floor, unsigned 4-bit compare.
REQ-019 IDLE: pending[current_floor]=1 and car_moving=0 -> DWELL; else above -> SERVE_UP; else below -> SERVE_DOWN; else stay.
REQ-020 SERVE_UP: target_floor SHALL be the lowest pending floor > current_floor; dir_up=1.
REQ-021 SERVE_DOWN: target_floor SHALL be the highest pending floor < current_floor; dir_up=0.
REQ-022 SERVE_x: current_floor==target_floor and car_moving=0 -> DWELL, clearing pending[current_floor] on the same edge.
REQ-023 SERVE_UP with no floor above: below -> SERVE_DOWN, none -> IDLE (SERVE_DOWN symmetric: above -> SERVE_UP).
REQ-024 A new request ahead of the car but nearer than target_floor SHALL replace target_floor on the next cycle (collective service).
REQ-025 DWELL SHALL last exactly DWELL_CYCLES clocks with door_open=1, via a counter cleared on entry.
REQ-026 DWELL exit: continue same direction if any floor ahead; else reverse if any behind; else IDLE; dir_up holds its value in DWELL.
REQ-027 IDLE with requests both above and below SHALL choose SERVE_UP.
REQ-028 target_floor SHALL equal current_floor in IDLE and DWELL.
REQ-029 Output latency: pending, target_floor, dir_up, door_open SHALL reflect inputs one clock after sampling.
REQ-030 Set and clear of the same pending bit on one edge: clear SHALL win.

Reset
REQ-031 rst_n=1 at an edge SHALL force IDLE, pending=0, target_floor=0, dir_up=1, door_open=0, req_reject=0, dwell counter=0, overriding all requests that cycle.
REQ-032 Reset mid-DWELL or mid-SERVE SHALL discard all pending requests; first request after rst_n=0 is accepted normally.

Verification
REQ-033 current_floor=0, request floor 5 -> pending=0x020 next cycle, SERVE_UP, target_floor=5, dir_up=1.
REQ-034 Car at 2 heading to 7, request 4 -> target_floor=4 next cycle; at floor 4 stopped: DWELL 4 cycles, pending[4]=0, then target_floor=7.
REQ-035 Car idle at 3, requests 1 and 6 same window -> SERVE_UP to 6, DWELL, then SERVE_DOWN to 1.
REQ-036 req_floor=12 (NUM_FLOORS=10) -> req_reject=1 one cycle, pending unchanged; request current floor in DWELL -> req_reject=1.
REQ-037 Idle at 4, request 4 -> pending[4]=1, next cycle DWELL, door_open=1 for 4 cycles, then IDLE with pending=0.
REQ-038 rst_n=1 during DWELL with pending=0x0C0 -> next edge IDLE, pending=0, door_open=0, target_floor=0.
